status_cond_unit: RTL and testbench
===================================

# status_cond_unit

Holds the architectural NZCV status register of the pipelined ARM core and evaluates the 4-bit condition field of the instruction leaving decode. The EXE-stage ALU produces flags; this block is their consumer. It captures them when the instruction carries the S bit and returns a registered pass/fail verdict to the ID/EXE boundary. It also feeds the stored carry back to the ALU for ADC/SBC.

## Interface
- No parameters; all widths fixed by the ISA.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- exe_valid  in  1  EXE stage holds a live instruction
- exe_s_bit  in  1  that instruction updates flags
- exe_status  in  4  ALU flags, order {N,Z,C,V}
- id_valid  in  1  ID stage holds a live instruction
- id_cond  in  4  ARM condition field of the ID instruction
- flush  in  1  branch taken; kill the ID instruction this cycle
- status  out  4  stored NZCV, {N,Z,C,V}; status[1] is the carry into the ALU
- hazard_stall  out  1  combinational; ID must hold this cycle
- cond_valid  out  1  registered; cond_pass is meaningful
- cond_pass  out  1  registered; condition satisfied

## Operation
- Flag write: if exe_valid & exe_s_bit, status_q <= exe_status at the rising edge. Otherwise status_q holds. Flush does not block this write, because the EXE instruction is older than the branch.
- Condition table on flags F: EQ 0000 Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 is 1; 1111 is 0 (never).
- Effective flags F (bypass build): exe_status if exe_valid & exe_s_bit, else status_q.
- Effective flags F (no-bypass build): always status_q.
- hazard_stall (no-bypass build only) = id_valid & exe_valid & exe_s_bit & (id_cond != 1110) & ~flush.
- hazard_stall is constant 0 in the bypass build.
- Verdict register, each edge:
  - cond_valid <= id_valid & ~flush & ~hazard_stall.
  - cond_pass <= eval(id_cond, F) when that same term is 1, else 0.

## Timing
- Reset (async assert, sync release by the environment):
  - status = 0000, cond_valid = 0, cond_pass = 0.
  - hazard_stall follows its inputs.
- Flag write latency: 1 cycle. status shows the new flags the cycle after the write.
- Verdict latency: 1 cycle from id_valid/id_cond.
- Stall sequencing in the no-bypass build:
  - Cycle n: ID is held, and cond_valid = 0 at n+1.
  - Cycle n+1: ID re-presents, status_q is now updated, and the verdict appears at n+2.
- Back-to-back S-updates each write in turn; the last writer wins.
- An AL instruction never stalls and always passes.
- Simultaneous flush and stall: flush wins. No stall is raised and cond_valid goes to 0.
- Reset mid-stream clears status and the verdict immediately. A pending write in that cycle is lost.

## Configuration
- STATUS_BYPASS_EN defined:
  - The EXE flags forward combinationally into the condition evaluation.
  - hazard_stall is tied to 0.
  - There is no bubble on a flag dependency.
- STATUS_BYPASS_EN undefined:
  - Evaluation sees only status_q.
  - hazard_stall is generated as above, costing one bubble per dependent conditional instruction.

## Structure
- Shared package arm_pkg holds:
  - condition-code constants COND_EQ..COND_NV;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - a 4-bit status_t typedef.
- One combinational sub-module, cond_eval (inputs cond and flags; output pass). It is reused by the branch unit.
- Status register, verdict registers and hazard logic stay in status_cond_unit.

## Test plan
- Reset: hold rst_n=0 mid-stream -> status=0000, cond_valid=0, cond_pass=0 asynchronously.
- Flag capture:
  - Stimulus: exe_valid=1, exe_s_bit=1, exe_status=0100; next cycle exe_s_bit=0, exe_status=1111.
  - Required: status=0100 and holds.
- Condition sweep:
  - Stimulus: preload each of the 16 NZCV values, then apply all 16 id_cond with no concurrent S-update.
  - Required: cond_pass matches the table one cycle later. With NZCV=1001, GE passes and LT fails. Code 1111 always fails.
- Dependency:
  - Stimulus: status=0000, EXE sets 0100 with the S bit while ID holds EQ.
  - Bypass build: cond_pass=1 next cycle, hazard_stall=0.
  - No-bypass build: hazard_stall=1, cond_valid=0; after re-present, cond_pass=1.
- Flush:
  - Stimulus: flush=1 with id_valid=1 and an EXE S-update of 0010.
  - Required: cond_valid=0, hazard_stall=0, status=0010 next cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM ISA definitions: status flag layout and condition-code encodings.
package arm_pkg;

    localparam int unsigned STATUS_W = 4;
    localparam int unsigned COND_W   = 4;

    typedef logic [STATUS_W-1:0] status_t;
    typedef logic [COND_W-1:0]   cond_t;

    // Bit positions inside an NZCV status word
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // ARM condition field encodings
    localparam cond_t COND_EQ = 4'b0000;
    localparam cond_t COND_NE = 4'b0001;
    localparam cond_t COND_CS = 4'b0010;
    localparam cond_t COND_CC = 4'b0011;
    localparam cond_t COND_MI = 4'b0100;
    localparam cond_t COND_PL = 4'b0101;
    localparam cond_t COND_VS = 4'b0110;
    localparam cond_t COND_VC = 4'b0111;
    localparam cond_t COND_HI = 4'b1000;
    localparam cond_t COND_LS = 4'b1001;
    localparam cond_t COND_GE = 4'b1010;
    localparam cond_t COND_LT = 4'b1011;
    localparam cond_t COND_GT = 4'b1100;
    localparam cond_t COND_LE = 4'b1101;
    localparam cond_t COND_AL = 4'b1110;
    localparam cond_t COND_NV = 4'b1111;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator; shared with the branch unit.
module cond_eval
    import arm_pkg::*;
(
    input  logic [COND_W-1:0]   cond,
    input  logic [STATUS_W-1:0] flags,
    output logic                pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// NZCV status register plus registered condition verdict for the ID instruction.
// Build option: define STATUS_BYPASS_EN to forward EXE flags into evaluation
// (no stall); leave it undefined to evaluate stored flags only and stall ID on
// a flag dependency.
module status_cond_unit
    import arm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exe_valid,
    input  logic                exe_s_bit,
    input  logic [STATUS_W-1:0] exe_status,
    input  logic                id_valid,
    input  logic [COND_W-1:0]   id_cond,
    input  logic                flush,
    output logic [STATUS_W-1:0] status,
    output logic                hazard_stall,
    output logic                cond_valid,
    output logic                cond_pass
);

    logic    flag_wr;
    status_t eval_flags;
    logic    eval_pass;
    logic    issue;

    // EXE instruction writes flags; flush never blocks it (EXE is older)
    assign flag_wr = exe_valid & exe_s_bit;

`ifdef STATUS_BYPASS_EN
    // Forward in-flight flags so dependent conditionals need no bubble
    assign eval_flags   = flag_wr ? exe_status : status;
    assign hazard_stall = 1'b0;
`else
    // Stored flags only; hold ID while a flag write is in flight, unless the
    // instruction is AL (flag-independent) or is being flushed anyway
    assign eval_flags   = status;
    assign hazard_stall = id_valid & flag_wr & (id_cond != COND_AL) & ~flush;
`endif

    assign issue = id_valid & ~flush & ~hazard_stall;

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (eval_flags),
        .pass  (eval_pass)
    );

    // Architectural status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else if (flag_wr) begin
            status <= exe_status;
        end
    end

    // Registered verdict returned to the ID/EXE boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_valid <= 1'b0;
            cond_pass  <= 1'b0;
        end else begin
            cond_valid <= issue;
            cond_pass  <= issue & eval_pass;
        end
    end

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench for status_cond_unit; honours STATUS_BYPASS_EN.
module tb_status_cond_unit;

`ifdef STATUS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       exe_valid;
    logic       exe_s_bit;
    logic [3:0] exe_status;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       flush;
    logic [3:0] status;
    logic       hazard_stall;
    logic       cond_valid;
    logic       cond_pass;

    int total;
    int bad;

    logic [3:0] model_status;

    status_cond_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exe_valid    (exe_valid),
        .exe_s_bit    (exe_s_bit),
        .exe_status   (exe_status),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .flush        (flush),
        .status       (status),
        .hazard_stall (hazard_stall),
        .cond_valid   (cond_valid),
        .cond_pass    (cond_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: codes pair up as (predicate, negation); bit 0 inverts.
    // Pair 7 (AL/NV) is "true" inverted, so 1111 never passes.
    function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n ^ v) == 1'b0;
            3'd6: base = !z && ((n ^ v) == 1'b0);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    // One clock of stimulus, with combinational and registered checks
    task automatic step(input bit ev, input bit sb, input logic [3:0] es,
                        input bit iv, input logic [3:0] ic, input bit fl);
        logic [3:0] f;
        bit wr, stall, vld, pss;
        @(negedge clk);
        exe_valid = ev; exe_s_bit = sb; exe_status = es;
        id_valid = iv; id_cond = ic; flush = fl;
        #1;
        wr    = ev && sb;
        f     = (BYPASS && wr) ? es : model_status;
        stall = !BYPASS && iv && wr && (ic != 4'd14) && !fl;
        vld   = iv && !fl && !stall;
        pss   = vld && ref_pass(ic, f);
        check("hazard_stall", {3'b0, hazard_stall}, {3'b0, stall});
        @(posedge clk);
        #1;
        if (wr) model_status = es;
        check("status", status, model_status);
        check("cond_valid", {3'b0, cond_valid}, {3'b0, vld});
        check("cond_pass", {3'b0, cond_pass}, {3'b0, pss});
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_status = 4'h0;
        rst_n = 1'b1;
        exe_valid = 0; exe_s_bit = 0; exe_status = 0;
        id_valid = 0; id_cond = 0; flush = 0;

        // Power-on reset, checked asynchronously before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_status", status, 4'h0);
        check("rst_cond_valid", {3'b0, cond_valid}, 4'h0);
        check("rst_cond_pass", {3'b0, cond_pass}, 4'h0);
        check("rst_hazard", {3'b0, hazard_stall}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag capture and hold
        step(1, 1, 4'b0100, 0, 4'h0, 0);
        step(1, 0, 4'b1111, 0, 4'h0, 0);
        check("capture_hold", status, 4'b0100);

        // Full sweep: every NZCV against every condition code
        for (int fv = 0; fv < 16; fv++) begin
            step(1, 1, 4'(fv), 0, 4'h0, 0);
            for (int cc = 0; cc < 16; cc++)
                step(0, 0, 4'h0, 1, 4'(cc), 0);
        end

        // NZCV=1001: GE passes, LT fails, NV fails
        step(1, 1, 4'b1001, 0, 4'h0, 0);
        step(0, 0, 4'h0, 1, 4'b1010, 0);
        check("ge_1001", {3'b0, cond_pass}, 4'h1);
        step(0, 0, 4'h0, 1, 4'b1011, 0);
        check("lt_1001", {3'b0, cond_pass}, 4'h0);
        step(0, 0, 4'h0, 1, 4'b1111, 0);
        check("nv_1001", {3'b0, cond_pass}, 4'h0);

        // Dependency: EQ in ID while EXE sets Z
        step(1, 1, 4'b0000, 0, 4'h0, 0);
        step(1, 1, 4'b0100, 1, 4'b0000, 0);
        if (!BYPASS) step(0, 0, 4'h0, 1, 4'b0000, 0);
        check("dep_pass", {3'b0, cond_pass}, 4'h1);

        // AL never stalls, even behind a flag write
        step(1, 1, 4'b0000, 1, 4'b1110, 0);

        // Flush with concurrent flag write
        step(1, 1, 4'b0010, 1, 4'b0001, 1);
        check("flush_status", status, 4'b0010);
        check("flush_valid", {3'b0, cond_valid}, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        // Mid-stream reset: verdict and status clear, pending write lost
        step(1, 1, 4'b1111, 0, 4'h0, 0);
        step(0, 0, 4'h0, 1, 4'b1110, 0);
        @(negedge clk);
        exe_valid = 1; exe_s_bit = 1; exe_status = 4'b1010;
        id_valid = 1; id_cond = 4'b1110; flush = 0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_status", status, 4'h0);
        check("mid_rst_valid", {3'b0, cond_valid}, 4'h0);
        check("mid_rst_pass", {3'b0, cond_pass}, 4'h0);
        @(posedge clk);
        #1;
        check("mid_rst_write_lost", status, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_status = 4'h0;
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
